keyboard_scan_ctrl: RTL and testbench
=====================================

Name: keyboard_scan_ctrl

Overview:
Scan sequencer for the 4x4 matrix keypad. It drives the row lines one at a time (active-low) and waits a programmable settle time before sampling the column lines. It assembles one 16-bit key snapshot per frame and publishes it with a frame strobe, lowest-key encoding and a multi-press flag. Its outputs feed the keyboard debounce filter and the key register block in place of a free-running scanner.

Parameters:
SETTLE_CYC, 16, clk cycles each row is driven before its columns are sampled; must be >=3 to cover the column synchronizer latency.
GAP_CYC, 64, idle clk cycles with all rows released between frames; 0 allowed.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
en  input  1  scan enable, level
col  input  4  column lines from pad, active-low (pulled up), asynchronous to clk
row  output  4  row drive, active-low, one-hot-zero while scanning, registered
key  output  16  latest complete frame; key[4*r+c]=1 when row r and col c are both low
scan_done  output  1  one-cycle pulse when key updates
any_key  output  1  |key, registered with key
key_code  output  4  index of lowest set bit of key; 0 when key==0
multi_key  output  1  popcount(key)>=2

Behaviour:
- Reset (async, rstn=0): row=4'hF, key=0, scan_done=0, any_key=0, key_code=0, multi_key=0, FSM=IDLE, counters=0, shadow=0, sync flops=4'hF. Reset asserted mid-frame aborts the frame immediately. After release, scanning restarts from row 0.
- col passes through a 2-FF synchronizer (reset value 4'hF). Only the synchronized value is used.
- FSM states: IDLE, DRIVE, GAP.
- IDLE: row=4'hF. If en=1, go to DRIVE with r=0 and cnt=0.
- DRIVE(r): row = ~(1<<r). cnt counts 0..SETTLE_CYC.
  - At cnt==SETTLE_CYC: shadow[4r+3:4r] <= ~col_sync.
  - If r<3: r<=r+1 and cnt<=0, so the next row is driven on the following cycle with no released cycle between rows.
  - If r==3: key<=shadow with row 3 bits merged, scan_done=1 for that one cycle, any_key/key_code/multi_key update in the same cycle as key. Then go to GAP with row=4'hF.
- GAP: row=4'hF for GAP_CYC cycles, then go to DRIVE(0) if en=1, else to IDLE. With GAP_CYC=0, DRIVE(0) follows immediately.
- Frame period = 4*(SETTLE_CYC+1) + GAP_CYC cycles. scan_done occurs on the cycle after row 3 is sampled.
- en=0 mid-frame: the current frame completes, including its scan_done; the block stops at the next GAP exit. key holds its last value while idle. en=1 in IDLE starts DRIVE(0) on the next cycle.
- No partial update: key changes only at scan_done, and all 16 bits change together.
- key_code is a priority encoder, lowest index wins: key=16'h8001 gives key_code=0 and multi_key=1.
- Ghosting (3 keys forming a rectangle) is not suppressed. Downstream reads multi_key.
- Counter width = $clog2(max(SETTLE_CYC,GAP_CYC)+1); no wrap can occur.

Test Plan:
- SETTLE_CYC=3, GAP_CYC=2, en=1, col=4'hF -> row sequence E,D,B,7 with each row held 4 cycles, then F for 2 cycles. scan_done every 18 cycles. key=0, any_key=0, key_code=0.
- Press (r=2,c=1): model drives col[1]=0 whenever row[2]=0 -> after the next scan_done, key=16'h0200, key_code=9, any_key=1, multi_key=0.
- Press (0,0) and (3,3) together -> key=16'h8001, key_code=0, multi_key=1. Release both -> key=0 at the next scan_done, not earlier.
- Deassert en during row 1 of a frame -> that frame completes with scan_done, then row stays F and no further scan_done appears. Reassert en -> row=E on the next cycle.
- Assert rstn=0 during row 2 with key=16'h0200 -> row=F and all outputs 0 immediately, without waiting for a clk edge. After release with en=1, the first row driven is E.
- GAP_CYC=0 -> row goes 7 then E on consecutive cycles, frame period 16 cycles with SETTLE_CYC=3.

Source files
------------

// File: rtl/keyboard_scan_ctrl_if.sv
// Keypad scan bundle: pad-side lines (row/col) and the published frame.
//
// Handshake: there is no back-pressure. scan_done is a one-cycle strobe that
// qualifies key/any_key/key_code/multi_key; those outputs hold their value
// until the next strobe, so a consumer may read them on the strobe cycle or
// any time afterwards.
interface keyboard_scan_ctrl_if;
    logic        en;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key;
    logic        scan_done;
    logic        any_key;
    logic [3:0]  key_code;
    logic        multi_key;

    // Scanner side: drives the rows and publishes frames.
    modport master (
        input  en, col,
        output row, key, scan_done, any_key, key_code, multi_key
    );

    // Pad/consumer side.
    modport slave (
        output en, col,
        input  row, key, scan_done, any_key, key_code, multi_key
    );
endinterface

// File: rtl/keyboard_scan_ctrl.sv
// 4x4 keypad scan sequencer. Drives one row low at a time, waits SETTLE_CYC
// cycles for the synchronized columns to settle, samples, and publishes a full
// 16-bit snapshot once per frame together with encoded summary outputs.
module keyboard_scan_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int GAP_CYC    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    keyboard_scan_ctrl_if.master  kif,
    output logic [1:0]            state_dbg
);

    localparam int MAX_CYC = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] GAP_LAST    = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         sample;
    logic         frame_end;

    logic [3:0]   col_meta, col_sync;
    logic [11:0]  shadow_q;
    logic [15:0]  frame_key;
    logic [3:0]   row_d;
    logic [3:0]   code_d;
    logic [4:0]   ones_d;

    logic [3:0]   row_q;
    logic [15:0]  key_q;
    logic         scan_done_q;
    logic         any_key_q;
    logic [3:0]   key_code_q;
    logic         multi_key_q;

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= kif.col;
            col_sync <= col_meta;
        end
    end

    // Next-state logic: row walk, settle/gap counting, sample and frame-end strobes.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        sample    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (kif.en) begin
                    state_d = DRIVE;
                    r_d     = 2'd0;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    sample = 1'b1;
                    cnt_d  = '0;
                    if (r_q != 2'd3) begin
                        r_d = r_q + 2'd1;
                    end else begin
                        frame_end = 1'b1;
                        r_d       = 2'd0;
                        // With no gap the enable decision happens right here.
                        if (GAP_CYC == 0) state_d = kif.en ? DRIVE : IDLE;
                        else              state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    r_d     = 2'd0;
                    state_d = kif.en ? DRIVE : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row drive follows the next state so the registered row lines up with it.
    always_comb begin
        row_d = 4'hF;
        if (state_d == DRIVE) row_d = ~(4'b0001 << r_d);
    end

    // Frame snapshot with row 3 merged, plus lowest-index encode and popcount.
    always_comb begin
        frame_key = {~col_sync, shadow_q};
        code_d    = 4'd0;
        ones_d    = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (frame_key[i]) code_d = 4'(i);
            ones_d = ones_d + {4'd0, frame_key[i]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            r_q     <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Row drive, shadow capture and frame publication.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q       <= 4'hF;
            shadow_q    <= '0;
            key_q       <= '0;
            scan_done_q <= 1'b0;
            any_key_q   <= 1'b0;
            key_code_q  <= 4'd0;
            multi_key_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            scan_done_q <= frame_end;
            if (sample && (r_q != 2'd3)) shadow_q[{r_q, 2'b00} +: 4] <= ~col_sync;
            if (frame_end) begin
                key_q       <= frame_key;
                any_key_q   <= |frame_key;
                key_code_q  <= code_d;
                multi_key_q <= (ones_d >= 5'd2);
            end
        end
    end

    assign kif.row       = row_q;
    assign kif.key       = key_q;
    assign kif.scan_done = scan_done_q;
    assign kif.any_key   = any_key_q;
    assign kif.key_code  = key_code_q;
    assign kif.multi_key = multi_key_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_keyboard_scan_ctrl.sv
// Bench for keyboard_scan_ctrl: a keypad model answers row drives with column
// pulls, and expected frames come from the pressed-key mask.
module tb_keyboard_scan_ctrl;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    keyboard_scan_ctrl_if kif ();
    keyboard_scan_ctrl_if kif0 ();
    logic [1:0]  st, st0;
    logic [15:0] pressed;
    logic [3:0]  col_v;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_key;

    keyboard_scan_ctrl #(.SETTLE_CYC(3), .GAP_CYC(2)) u_dut (
        .clk(clk), .rstn(rstn), .kif(kif.master), .state_dbg(st));
    keyboard_scan_ctrl #(.SETTLE_CYC(3), .GAP_CYC(0)) u_gap0 (
        .clk(clk), .rstn(rstn), .kif(kif0.master), .state_dbg(st0));

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kif.row[r] && pressed[4*r+c]) col_v[c] = 1'b0;
    end
    assign kif.col  = col_v;
    assign kif0.col = 4'hF;
    assign kif0.en  = 1'b1;

    // Reference helpers computed from the key map rules.
    function automatic logic [3:0] ref_code(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return 4'(i);
        return 4'd0;
    endfunction

    function automatic int ref_pop(input logic [15:0] k);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(k[i]);
        return n;
    endfunction

    // Row expected at a given cycle of a frame: four rows of 4 cycles, then released.
    function automatic logic [3:0] ref_row(input int phase);
        logic [3:0] one = 4'b0001;
        if (phase < 16) return ~(one << (phase / 4));
        return 4'hF;
    endfunction

    // Sync to a frame boundary, apply a press mask for the whole next frame.
    task automatic drive_frame(input logic [15:0] mask, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.scan_done) begin ok = 1'b1; break; end
        end
        pressed = mask;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (kif.scan_done) begin ok = 1'b1; break; end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; kif.en = 1'b0; pressed = 16'h0;
        repeat (3) @(negedge clk);
        checks++; if (kif.row !== 4'hF) begin errors++; $display("FAIL reset_row got=%h want=F", kif.row); end
        checks++; if (kif.key !== 16'h0) begin errors++; $display("FAIL reset_key got=%h want=0", kif.key); end
        checks++; if ({kif.scan_done, kif.any_key, kif.multi_key} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got=%b want=000", {kif.scan_done, kif.any_key, kif.multi_key}); end
        checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d want=0", kif.key_code); end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++; if (kif.row !== 4'hF || kif.scan_done !== 1'b0) begin errors++;
                $display("FAIL idle_hold row=%h done=%b want F/0", kif.row, kif.scan_done); end
        end
    endtask

    task automatic test_row_sequence();
        kif.en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            checks++; if (kif.row !== ref_row(t % 18)) begin errors++;
                $display("FAIL row_seq t=%0d got=%h want=%h", t, kif.row, ref_row(t % 18)); end
            checks++; if (kif.scan_done !== ((t % 18) == 16)) begin errors++;
                $display("FAIL done_period t=%0d got=%b want=%b", t, kif.scan_done, (t % 18) == 16); end
        end
        checks++; if ({kif.key, kif.any_key, kif.key_code} !== 21'h0) begin errors++;
            $display("FAIL idle_key key=%h any=%b code=%0d want 0", kif.key, kif.any_key, kif.key_code); end
    endtask

    task automatic test_single_key();
        bit ok;
        drive_frame(16'h0200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=no_done want=done"); end
        checks++; if (kif.key !== 16'h0200) begin errors++; $display("FAIL single_key got=%h want=0200", kif.key); end
        checks++; if (kif.key_code !== 4'd9) begin errors++; $display("FAIL single_code got=%0d want=9", kif.key_code); end
        checks++; if ({kif.any_key, kif.multi_key} !== 2'b10) begin errors++;
            $display("FAIL single_flags got=%b want=10", {kif.any_key, kif.multi_key}); end
    endtask

    task automatic test_multi_key();
        bit ok;
        int early = 0;
        drive_frame(16'h8001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_timeout got=no_done want=done"); end
        checks++; if (kif.key !== 16'h8001) begin errors++; $display("FAIL multi_key got=%h want=8001", kif.key); end
        checks++; if ({kif.key_code, kif.multi_key, kif.any_key} !== 6'b0000_11) begin errors++;
            $display("FAIL multi_enc code=%0d multi=%b any=%b want 0/1/1", kif.key_code, kif.multi_key, kif.any_key); end
        pressed = 16'h0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.scan_done) begin ok = 1'b1; break; end
            if (kif.key !== 16'h8001) early++;
        end
        checks++; if (!ok || early != 0) begin errors++;
            $display("FAIL release_hold done=%b early_changes=%0d want 1/0", ok, early); end
        checks++; if ({kif.key, kif.any_key, kif.multi_key, kif.key_code} !== 22'h0) begin errors++;
            $display("FAIL release_key key=%h any=%b multi=%b code=%0d want 0", kif.key, kif.any_key, kif.multi_key, kif.key_code); end
    endtask

    task automatic test_random_keys();
        bit ok;
        logic [15:0] mask, exp;
        for (int n = 0; n < 8; n++) begin
            mask = 16'($urandom_range(0, 65535));
            if (n % 3 == 0) mask = 16'h1 << $urandom_range(0, 15);
            exp_q.push_back(mask);
            drive_frame(mask, ok);
            exp = exp_q.pop_front();
            checks++; if (!ok || kif.key !== exp) begin errors++;
                $display("FAIL rand_key n=%0d done=%b got=%h want=%h", n, ok, kif.key, exp); end
            checks++; if (kif.key_code !== ref_code(exp) || kif.any_key !== (exp != 0) ||
                          kif.multi_key !== (ref_pop(exp) >= 2)) begin errors++;
                $display("FAIL rand_enc n=%0d code=%0d any=%b multi=%b want %0d/%b/%b", n, kif.key_code,
                         kif.any_key, kif.multi_key, ref_code(exp), exp != 0, ref_pop(exp) >= 2); end
            last_key = exp;
        end
    endtask

    task automatic test_en_stop();
        bit ok = 1'b0;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.row == 4'hD) begin ok = 1'b1; break; end
        end
        kif.en = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (kif.scan_done) begin ok = 1'b1; break; end
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL en_stop_done got=no_done want=done"); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.row !== 4'hF || kif.scan_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL en_stop_idle bad_cycles=%0d want=0", bad); end
        checks++; if (kif.key !== last_key) begin errors++; $display("FAIL en_stop_hold got=%h want=%h", kif.key, last_key); end
        kif.en = 1'b1;
        @(negedge clk);
        checks++; if (kif.row !== 4'hE) begin errors++; $display("FAIL en_restart got=%h want=E", kif.row); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        drive_frame(16'h0200, ok);
        checks++; if (!ok || kif.key !== 16'h0200) begin errors++;
            $display("FAIL pre_reset_key got=%h want=0200", kif.key); end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.row == 4'hB) begin ok = 1'b1; break; end
        end
        rstn = 1'b0;
        #1;
        checks++; if (!ok || kif.row !== 4'hF) begin errors++; $display("FAIL async_reset_row got=%h want=F", kif.row); end
        checks++; if ({kif.key, kif.scan_done, kif.any_key, kif.multi_key, kif.key_code} !== 23'h0) begin errors++;
            $display("FAIL async_reset_out key=%h code=%0d any=%b want 0", kif.key, kif.key_code, kif.any_key); end
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (kif.row != 4'hF) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || kif.row !== 4'hE) begin errors++; $display("FAIL restart_row got=%h want=E", kif.row); end
    endtask

    task automatic test_gap_zero();
        bit ok = 1'b0;
        logic [3:0] prev = kif0.row;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif0.row == 4'hE && prev != 4'hE) begin ok = 1'b1; break; end
            prev = kif0.row;
        end
        checks++; if (!ok) begin errors++; $display("FAIL gap0_sync got=no_row0 want=row0"); end
        for (int t = 1; t < 40; t++) begin
            @(negedge clk);
            checks++; if (kif0.row !== ref_row(t % 16)) begin errors++;
                $display("FAIL gap0_row t=%0d got=%h want=%h", t, kif0.row, ref_row(t % 16)); end
            checks++; if (kif0.scan_done !== ((t % 16) == 0)) begin errors++;
                $display("FAIL gap0_done t=%0d got=%b want=%b", t, kif0.scan_done, (t % 16) == 0); end
        end
    endtask

    initial begin
        last_key = 16'h0;
        test_reset();
        test_row_sequence();
        test_single_key();
        test_multi_key();
        test_random_keys();
        test_en_stop();
        test_reset_midframe();
        test_gap_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
